// File: rtl/flmult_pipe_if.sv
// Operand/result handshake bundle for the pipelined float multiplier.
// The producer/consumer side uses master; the multiplier uses slave.
interface flmult_pipe_if #(
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      num1;
  logic [31:0]      num2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      result;
  logic [TAG_W-1:0] out_tag;
  logic             ovf;
  logic             unf;

  modport master (
    output in_valid, num1, num2, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, ovf, unf
  );

  modport slave (
    input  in_valid, num1, num2, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, ovf, unf
  );
endinterface

// File: rtl/flmult_pipe.sv
// 3-stage IEEE-754 single multiplier: unpack/classify, mantissa product,
// normalise/round/pack. A single global enable stalls every stage at once.
module flmult_pipe #(
  parameter int MAN_BITS = 14,
  parameter int ROUND    = 0,
  parameter int TAG_W    = 8
) (
  input logic          clk,
  input logic          rst,
  flmult_pipe_if.slave bus
);
  localparam int W = 2 * MAN_BITS;

  logic en;
  assign en = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  logic [7:0]  e1, e2;
  logic [22:0] f1, f2;
  logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, sign_c;
  logic        spec_c;
  logic [31:0] spec_val_c;
  logic signed [9:0] esum_c;

  assign e1 = bus.num1[30:23];
  assign e2 = bus.num2[30:23];
  assign f1 = bus.num1[22:0];
  assign f2 = bus.num2[22:0];
  assign zero_a = (e1 == 8'h00);
  assign zero_b = (e2 == 8'h00);
  assign inf_a  = (e1 == 8'hFF) && (f1 == 23'd0);
  assign inf_b  = (e2 == 8'hFF) && (f2 == 23'd0);
  assign nan_a  = (e1 == 8'hFF) && (f1 != 23'd0);
  assign nan_b  = (e2 == 8'hFF) && (f2 != 23'd0);
  assign sign_c = bus.num1[31] ^ bus.num2[31];
  assign esum_c = $signed({2'b00, e1} + {2'b00, e2} - 10'd127);

  // Special cases are resolved up front and simply ride down the pipe.
  always_comb begin
    spec_c     = 1'b1;
    spec_val_c = 32'h0000_0000;
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b))
      spec_val_c = 32'h7FC0_0000;
    else if (inf_a || inf_b)
      spec_val_c = {sign_c, 8'hFF, 23'd0};
    else if (zero_a || zero_b)
      spec_val_c = 32'h0000_0000;
    else
      spec_c = 1'b0;
  end

  logic                v1, v2;
  logic                sign1, sign2, spec1, spec2;
  logic [31:0]         spec_val1, spec_val2;
  logic [MAN_BITS-1:0] ma1, mb1;
  logic signed [9:0]   esum1, esum2;
  logic [TAG_W-1:0]    tag1, tag2;
  logic [W-1:0]        prod2;

  always_ff @(posedge clk) begin
    if (en) begin
      sign1     <= sign_c;
      spec1     <= spec_c;
      spec_val1 <= spec_val_c;
      ma1       <= {1'b1, f1[22 -: MAN_BITS-1]};
      mb1       <= {1'b1, f2[22 -: MAN_BITS-1]};
      esum1     <= esum_c;
      tag1      <= bus.in_tag;
      sign2     <= sign1;
      spec2     <= spec1;
      spec_val2 <= spec_val1;
      esum2     <= esum1;
      tag2      <= tag1;
      prod2     <= W'(ma1) * W'(mb1);
    end
  end

  logic [W-2:0]      pn;
  logic [22:0]       frac;
  logic              guard, sticky, inc;
  logic [23:0]       frac_r;
  logic signed [9:0] exp_n;
  logic [31:0]       res_c;
  logic              ovf_c, unf_c;

  // pn drops the leading one, so frac/guard/sticky sit at fixed positions.
  always_comb begin
    pn     = prod2[W-1] ? prod2[W-2:0] : {prod2[W-3:0], 1'b0};
    frac   = pn[W-2 -: 23];
    guard  = pn[W-25];
    sticky = |pn[W-26:0];
    inc    = (ROUND != 0) && guard && (sticky || frac[0]);
    frac_r = {1'b0, frac} + {23'd0, inc};
    exp_n  = esum2 + {9'd0, prod2[W-1]} + {9'd0, frac_r[23]};
    res_c  = {sign2, exp_n[7:0], frac_r[22:0]};
    ovf_c  = 1'b0;
    unf_c  = 1'b0;
    if (spec2) begin
      res_c = spec_val2;
    end else if (exp_n >= 10'sd255) begin
      res_c = {sign2, 8'hFF, 23'd0};
      ovf_c = 1'b1;
    end else if (exp_n <= 10'sd0) begin
      res_c = 32'h0000_0000;
      unf_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.result    <= 32'h0000_0000;
      bus.out_tag   <= '0;
      bus.ovf       <= 1'b0;
      bus.unf       <= 1'b0;
    end else if (en) begin
      v1            <= bus.in_valid;
      v2            <= v1;
      bus.out_valid <= v2;
      if (v2) begin
        bus.result  <= res_c;
        bus.out_tag <= tag2;
        bus.ovf     <= ovf_c;
        bus.unf     <= unf_c;
      end
    end
  end
endmodule

// File: tb/tb_flmult_pipe.sv
// Directed bench: default-precision multiplier plus two full-precision
// copies (truncate / round-to-even) driven in lockstep.
module tb_flmult_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] num1 = 32'h0;
  logic [31:0] num2 = 32'h0;
  logic [7:0]  in_tag = 8'h0;
  logic        out_ready = 1'b1;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  flmult_pipe_if #(.TAG_W(8)) ifa ();
  flmult_pipe_if #(.TAG_W(8)) ifb ();
  flmult_pipe_if #(.TAG_W(8)) ifc ();

  assign ifa.in_valid = in_valid;
  assign ifa.num1 = num1;
  assign ifa.num2 = num2;
  assign ifa.in_tag = in_tag;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid = in_valid;
  assign ifb.num1 = num1;
  assign ifb.num2 = num2;
  assign ifb.in_tag = in_tag;
  assign ifb.out_ready = out_ready;
  assign ifc.in_valid = in_valid;
  assign ifc.num1 = num1;
  assign ifc.num2 = num2;
  assign ifc.in_tag = in_tag;
  assign ifc.out_ready = out_ready;

  flmult_pipe #(.MAN_BITS(14), .ROUND(0), .TAG_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  flmult_pipe #(.MAN_BITS(24), .ROUND(0), .TAG_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  flmult_pipe #(.MAN_BITS(24), .ROUND(1), .TAG_W(8)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  // Issue one op with out_ready high and return once its result is visible.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] tag, output int lat);
    @(negedge clk);
    num1 = a;
    num2 = b;
    in_tag = tag;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!ifa.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ifa.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", ifa.out_valid); end
    n_vec++;
    if (ifa.result !== 32'h0) begin n_err++; $display("[TB] FAIL reset_result: got %h, expected 00000000", ifa.result); end
    n_vec++;
    if (ifa.out_tag !== 8'h0) begin n_err++; $display("[TB] FAIL reset_out_tag: got %h, expected 00", ifa.out_tag); end
    n_vec++;
    if ({ifa.ovf, ifa.unf} !== 2'b00) begin n_err++; $display("[TB] FAIL reset_flags: got %b, expected 00", {ifa.ovf, ifa.unf}); end
    n_vec++;
    if (ifa.in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", ifa.in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    do_op(32'h4000_0000, 32'h4040_0000, 8'h11, lat);
    n_vec++;
    if (lat !== 3) begin n_err++; $display("[TB] FAIL basic_latency: got %0d, expected 3", lat); end
    n_vec++;
    if (ifa.result !== 32'h40C0_0000) begin n_err++; $display("[TB] FAIL basic_result: got %h, expected 40c00000", ifa.result); end
    n_vec++;
    if (ifa.out_tag !== 8'h11) begin n_err++; $display("[TB] FAIL basic_tag: got %h, expected 11", ifa.out_tag); end
    n_vec++;
    if ({ifa.ovf, ifa.unf} !== 2'b00) begin n_err++; $display("[TB] FAIL basic_flags: got %b, expected 00", {ifa.ovf, ifa.unf}); end
  endtask

  task automatic test_back_to_back();
    int guard_cnt;
    @(negedge clk);
    out_ready = 1'b1;
    num1 = 32'hC000_0000; num2 = 32'h4040_0000; in_tag = 8'h31; in_valid = 1'b1;
    @(negedge clk);
    num1 = 32'h3FC0_0000; num2 = 32'h3FC0_0000; in_tag = 8'h32;
    @(negedge clk);
    in_valid = 1'b0;
    guard_cnt = 0;
    while (!ifa.out_valid && guard_cnt < 10) begin
      @(negedge clk);
      guard_cnt++;
    end
    n_vec++;
    if (ifa.result !== 32'hC0C0_0000 || ifa.out_valid !== 1'b1) begin
      n_err++; $display("[TB] FAIL b2b_first: got %h valid %b, expected c0c00000 valid 1", ifa.result, ifa.out_valid);
    end
    @(negedge clk);
    n_vec++;
    if (ifa.result !== 32'h4010_0000 || ifa.out_valid !== 1'b1) begin
      n_err++; $display("[TB] FAIL b2b_second: got %h valid %b, expected 40100000 valid 1", ifa.result, ifa.out_valid);
    end
    n_vec++;
    if (ifa.out_tag !== 8'h32) begin n_err++; $display("[TB] FAIL b2b_tag: got %h, expected 32", ifa.out_tag); end
    @(negedge clk);
    n_vec++;
    if (ifa.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_drain: got %b, expected 0", ifa.out_valid); end
  endtask

  task automatic test_range();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] vr [3];
    logic [1:0]  vf [3];
    int lat;
    va[0] = 32'h7F00_0000; vb[0] = 32'h7F00_0000; vr[0] = 32'h7F80_0000; vf[0] = 2'b10;
    va[1] = 32'h0080_0000; vb[1] = 32'h0080_0000; vr[1] = 32'h0000_0000; vf[1] = 2'b01;
    va[2] = 32'h0000_0000; vb[2] = 32'h4000_0000; vr[2] = 32'h0000_0000; vf[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], 8'(8'h40 + i), lat);
      n_vec++;
      if (ifa.result !== vr[i]) begin n_err++; $display("[TB] FAIL range_result[%0d]: got %h, expected %h", i, ifa.result, vr[i]); end
      n_vec++;
      if ({ifa.ovf, ifa.unf} !== vf[i]) begin n_err++; $display("[TB] FAIL range_flags[%0d]: got %b, expected %b", i, {ifa.ovf, ifa.unf}, vf[i]); end
    end
  endtask

  task automatic test_special();
    int lat;
    do_op(32'h7F80_0000, 32'h0000_0000, 8'h51, lat);
    n_vec++;
    if (ifa.result !== 32'h7FC0_0000) begin n_err++; $display("[TB] FAIL inf_times_zero: got %h, expected 7fc00000", ifa.result); end
    do_op(32'hFF80_0000, 32'h4000_0000, 8'h52, lat);
    n_vec++;
    if (ifa.result !== 32'hFF80_0000) begin n_err++; $display("[TB] FAIL neg_inf: got %h, expected ff800000", ifa.result); end
    n_vec++;
    if ({ifa.ovf, ifa.unf} !== 2'b00) begin n_err++; $display("[TB] FAIL neg_inf_flags: got %b, expected 00", {ifa.ovf, ifa.unf}); end
  endtask

  task automatic test_rounding();
    int lat;
    do_op(32'h3F80_0001, 32'h3FC0_0000, 8'h61, lat);
    n_vec++;
    if (ifb.result !== 32'h3FC0_0001) begin n_err++; $display("[TB] FAIL full_trunc: got %h, expected 3fc00001", ifb.result); end
    n_vec++;
    if (ifc.result !== 32'h3FC0_0002) begin n_err++; $display("[TB] FAIL full_round: got %h, expected 3fc00002", ifc.result); end
    n_vec++;
    if (ifa.result !== 32'h3FC0_0000) begin n_err++; $display("[TB] FAIL short_mantissa: got %h, expected 3fc00000", ifa.result); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_res [3];
    logic [7:0]  exp_tag [3];
    logic [31:0] got_res [3];
    logic [7:0]  got_tag [3];
    int n_got;
    exp_res[0] = 32'h40C0_0000; exp_tag[0] = 8'h21;
    exp_res[1] = 32'h4010_0000; exp_tag[1] = 8'h22;
    exp_res[2] = 32'hC0C0_0000; exp_tag[2] = 8'h23;
    @(negedge clk);
    out_ready = 1'b0;
    num1 = 32'h4000_0000; num2 = 32'h4040_0000; in_tag = 8'h21; in_valid = 1'b1;
    @(negedge clk);
    num1 = 32'h3FC0_0000; num2 = 32'h3FC0_0000; in_tag = 8'h22;
    @(negedge clk);
    num1 = 32'hC000_0000; num2 = 32'h4040_0000; in_tag = 8'h23;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b1 || ifa.result !== exp_res[0] || ifa.out_tag !== exp_tag[0]) begin
        n_err++;
        $display("[TB] FAIL stall_hold[%0d]: got rdy %b vld %b res %h tag %h, expected rdy 0 vld 1 res %h tag %h",
                 i, ifa.in_ready, ifa.out_valid, ifa.result, ifa.out_tag, exp_res[0], exp_tag[0]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    n_got = 0;
    for (int i = 0; i < 6; i++) begin
      if (ifa.out_valid) begin
        if (n_got < 3) begin
          got_res[n_got] = ifa.result;
          got_tag[n_got] = ifa.out_tag;
        end
        n_got++;
      end
      @(negedge clk);
    end
    n_vec++;
    if (n_got !== 3) begin n_err++; $display("[TB] FAIL stall_count: got %0d, expected 3", n_got); end
    for (int i = 0; i < 3; i++) begin
      if (i < n_got) begin
        n_vec++;
        if (got_res[i] !== exp_res[i] || got_tag[i] !== exp_tag[i]) begin
          n_err++;
          $display("[TB] FAIL stall_order[%0d]: got %h/%h, expected %h/%h", i, got_res[i], got_tag[i], exp_res[i], exp_tag[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    out_ready = 1'b1;
    num1 = 32'h4000_0000; num2 = 32'h4000_0000; in_tag = 8'h71; in_valid = 1'b1;
    @(negedge clk);
    in_tag = 8'h72;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (ifa.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_valid: got %b, expected 0", ifa.out_valid); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifa.out_valid) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("[TB] FAIL midreset_stale: got %0d results, expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_range();
    test_special();
    test_rounding();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
